// File: rtl/coder_pkg.sv
// rtl/coder_pkg.sv - shared constants and FSM encoding for the coefficient RAM arbiter
package coder_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  localparam logic [1:0] REQ_WAV  = 2'd0;
  localparam logic [1:0] REQ_WIN  = 2'd1;
  localparam logic [1:0] REQ_HOST = 2'd2;

  typedef enum logic {
    FREE = 1'b0,
    HELD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational 3-way one-hot picker with rotating base and demote mask
module arb_pick (
  input  logic [2:0] req,
  input  logic [1:0] base,
  input  logic [2:0] demote,
  output logic [2:0] win
);

  logic [2:0] pref;
  logic [2:0] pool;
  logic [1:0] idx;
  int         s;

  always_comb begin
    pref = req & ~demote;
    // Demoted requesters only win when nobody else is asking.
    pool = (pref != 3'b000) ? pref : req;
    win  = 3'b000;
    idx  = 2'd0;
    s    = 0;
    // Walk from lowest to highest priority so the base slot overrides last.
    for (int i = 2; i >= 0; i--) begin
      s = int'(base) + i;
      if (s >= 3) s = s - 3;
      idx = 2'(s);
      if (pool[idx]) win = 3'b001 << idx;
    end
  end

endmodule

// File: rtl/coef_ram_arbiter.sv
// rtl/coef_ram_arbiter.sv - lockable 3-requester arbiter for the coefficient RAM
// COEF_ARB_RR_EN: round-robin arbitration instead of fixed R0 > R1 > R2.
module coef_ram_arbiter
  import coder_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [2:0]    lock,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          lock_overrun
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    demote_q, demote_d;
  logic          ovr_q, ovr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]    tag_q, tag_d;
  logic          rd_q, rd_d;
  logic [2:0]    rvalid_q, rvalid_d;

  logic [2:0]    win;
  logic [2:0]    owner_oh;
  logic [1:0]    base;
  logic [1:0]    sel;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic          unused_we;

  assign unused_we = ^we[2:1];

`ifdef COEF_ARB_RR_EN
  logic [1:0] rr_q, rr_d;
  assign base = rr_q;
`else
  assign base = REQ_WAV;
`endif

  arb_pick u_pick (
    .req    (req),
    .base   (base),
    .demote (demote_q),
    .win    (win)
  );

  always_comb begin
    owner_oh = 3'b001 << owner_q;
    gnt      = (state_q == FREE) ? win : (owner_oh & req);
    accept   = (gnt != 3'b000);
    sel      = gnt[2] ? REQ_HOST : (gnt[1] ? REQ_WIN : REQ_WAV);
    case (sel)
      REQ_WIN:  sel_addr = addr1;
      REQ_HOST: sel_addr = addr2;
      default:  sel_addr = addr0;
    endcase

    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    demote_d    = demote_q;
    ovr_d       = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag_d       = tag_q;
    rd_d        = 1'b0;
    rvalid_d    = rd_q ? (3'b001 << tag_q) : 3'b000;
`ifdef COEF_ARB_RR_EN
    rr_d        = rr_q;
`endif

    if (state_q == FREE) begin
      if (req != 3'b000) demote_d = 3'b000;
      if (accept) begin
`ifdef COEF_ARB_RR_EN
        rr_d = (sel == REQ_HOST) ? REQ_WAV : sel + 2'd1;
`endif
        if (lock[sel]) begin
          if (CW'(LOCK_MAX) == CW'(1)) begin
            ovr_d    = 1'b1;
            demote_d = gnt;
          end else begin
            state_d = HELD;
            owner_d = sel;
            cnt_d   = CW'(1);
          end
        end
      end
    end else if (accept) begin
      if (lock[owner_q] && (CW'(cnt_q + 1'b1) == CW'(LOCK_MAX))) begin
        state_d  = FREE;
        cnt_d    = '0;
        ovr_d    = 1'b1;
        demote_d = owner_oh;
      end else if (lock[owner_q]) begin
        cnt_d = CW'(cnt_q + 1'b1);
      end else begin
        state_d = FREE;
        cnt_d   = '0;
      end
    end else if (!lock[owner_q]) begin
      state_d = FREE;
      cnt_d   = '0;
    end

    // Only the wavelet engine may write; other requesters are served as reads.
    if (accept) begin
      ram_addr_d  = sel_addr;
      ram_we_d    = (sel == REQ_WAV) && we[0];
      ram_wdata_d = wdata0;
      tag_d       = sel;
      rd_d        = !ram_we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FREE;
      owner_q     <= REQ_WAV;
      cnt_q       <= '0;
      demote_q    <= 3'b000;
      ovr_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag_q       <= 2'd0;
      rd_q        <= 1'b0;
      rvalid_q    <= 3'b000;
`ifdef COEF_ARB_RR_EN
      rr_q        <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      demote_q    <= demote_d;
      ovr_q       <= ovr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag_q       <= tag_d;
      rd_q        <= rd_d;
      rvalid_q    <= rvalid_d;
`ifdef COEF_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign rvalid       = rvalid_q;
  assign rdata        = (rvalid_q != 3'b000) ? ram_rdata : '0;
  assign ram_addr     = ram_addr_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = ram_wdata_q;
  assign lock_overrun = ovr_q;

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// tb/tb_coef_ram_arbiter.sv - scoreboard bench for coef_ram_arbiter with a behavioural RAM
module tb_coef_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = '0, lock = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we, lock_overrun;

  logic [DW-1:0] mem   [4096];
  logic [DW-1:0] model [4096];
  logic [17:0]   sbq[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  coef_ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .wdata0(wdata0),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .lock_overrun(lock_overrun)
  );

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]   = 16'(i * 7) ^ 16'h5A00;
      model[i] = 16'(i * 7) ^ 16'h5A00;
    end
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalid !== 3'b000) begin
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 32'(rvalid), 32'd0);
      end else begin
        logic [17:0] e;
        e = sbq.pop_front();
        chk("rvalid_tag", 32'(rvalid), 32'(3'b001 << e[17:16]));
        chk("rdata", 32'(rdata), 32'(e[15:0]));
      end
    end
  end

  task automatic exp_rd(input logic [1:0] idx, input logic [AW-1:0] a);
    sbq.push_back({idx, model[a]});
  endtask

  task automatic step(input logic [2:0] eg, input string nm);
    @(negedge clk);
    chk(nm, 32'(gnt), 32'(eg));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0; lock = '0; we = '0;
    for (int i = 0; i < n; i++) step(3'b000, "idle_gnt");
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({nm, "_rdata"}, 32'(rdata), 32'd0);
    chk({nm, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({nm, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({nm, "_overrun"}, 32'(lock_overrun), 32'd0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single read, 2-cycle latency
    addr1 = 12'd4032; req = 3'b010; exp_rd(2'd1, 12'd4032);
    step(3'b010, "t1_gnt");
    req = 3'b000;
    chk("t1_ram_addr", 32'(ram_addr), 32'd4032);
    chk("t1_ram_we", 32'(ram_we), 32'd0);
    step(3'b000, "t1_idle");
    chk("t1_rvalid_n2", 32'(rvalid), 32'b010);
    idle(2);

    // write then read-back, plus ignored write from R2
    req = 3'b001; we = 3'b001; addr0 = 12'd5; wdata0 = 16'h1234; model[5] = 16'h1234;
    step(3'b001, "t2_wr_gnt");
    chk("t2_ram_we", 32'(ram_we), 32'd1);
    chk("t2_ram_wdata", 32'(ram_wdata), 32'h1234);
    chk("t2_ram_addr", 32'(ram_addr), 32'd5);
    req = 3'b100; we = 3'b000; addr2 = 12'd5; exp_rd(2'd2, 12'd5);
    step(3'b100, "t2_rd_gnt");
    chk("t2_rd_ram_we", 32'(ram_we), 32'd0);
    req = 3'b100; we = 3'b100; addr2 = 12'd7; exp_rd(2'd2, 12'd7);
    step(3'b100, "t2_r2_we_gnt");
    chk("t2_r2_we_ignored", 32'(ram_we), 32'd0);
    chk("t2_r2_addr", 32'(ram_addr), 32'd7);
    idle(3);

    // all three requesting
    req = 3'b111; addr0 = 12'd10; addr1 = 12'd20; addr2 = 12'd30;
`ifdef COEF_ARB_RR_EN
    exp_rd(2'd0, 12'd10); step(3'b001, "t3_rr0");
    exp_rd(2'd1, 12'd20); step(3'b010, "t3_rr1");
    exp_rd(2'd2, 12'd30); step(3'b100, "t3_rr2");
`else
    for (int i = 0; i < 3; i++) begin
      exp_rd(2'd0, 12'd10); step(3'b001, "t3_fixed");
    end
`endif
    idle(3);

    // R1 locked burst with R0 waiting and an owner pause
    req = 3'b010; lock = 3'b010; addr1 = 12'd100; exp_rd(2'd1, 12'd100);
    step(3'b010, "t4_b1");
    req = 3'b011; addr0 = 12'd50; addr1 = 12'd164; exp_rd(2'd1, 12'd164);
    step(3'b010, "t4_b2");
    req = 3'b001;
    step(3'b000, "t4_owner_pause");
    req = 3'b011; lock = 3'b000; addr1 = 12'd228; exp_rd(2'd1, 12'd228);
    step(3'b010, "t4_b3");
    req = 3'b001; exp_rd(2'd0, 12'd50);
    step(3'b001, "t4_r0_after");
    idle(3);

    // R0 lock overrun at LOCK_MAX=8 with R1 waiting
    req = 3'b001; lock = 3'b001; addr0 = 12'd200; exp_rd(2'd0, 12'd200);
    step(3'b001, "t5_beat");
    req = 3'b011; addr1 = 12'd300;
    for (int b = 2; b <= 8; b++) begin
      addr0 = 12'(200 + b); exp_rd(2'd0, 12'(200 + b));
      chk("t5_no_early_ovr", 32'(lock_overrun), 32'd0);
      step(3'b001, "t5_beat");
    end
    chk("t5_overrun", 32'(lock_overrun), 32'd1);
    exp_rd(2'd1, 12'd300);
    step(3'b010, "t5_r1_after_ovr");
    chk("t5_overrun_pulse", 32'(lock_overrun), 32'd0);
    req = 3'b001;
    for (int b = 0; b < 3; b++) begin
      addr0 = 12'(220 + b); exp_rd(2'd0, 12'(220 + b));
      step(3'b001, "t5_relock");
    end
    req = 3'b000; lock = 3'b000;
    step(3'b000, "t5_release");
    req = 3'b010; addr1 = 12'd400; exp_rd(2'd1, 12'd400);
    step(3'b010, "t5_free_again");
    idle(3);

    // reset while a read is in flight
    req = 3'b010; addr1 = 12'd9;
    step(3'b010, "t6_gnt");
    req = 3'b000;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_in_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk_zero("t6_after");

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
